// File: rtl/alert_scheduler.sv
// Alert scheduler: grants one speaker channel at a time for a fixed-length slot
// with a square-wave tone, separated by silent gaps.
// Build option: define ALERT_FIXED_PRIORITY_EN for fixed priority arbitration
// (bit0 > bit1 > bit2). Without it, arbitration is round-robin.
module alert_scheduler #(
    parameter int unsigned SLOT_LEN = 1000,
    parameter int unsigned GAP_LEN  = 100,
    parameter int unsigned TONE_DIV = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [2:0] req,
    output logic [2:0] spk,
    output logic       tone,
    output logic       busy,
    output logic [1:0] grant_idx
);

    localparam logic [15:0] SlotLast = 16'(SLOT_LEN - 1);
    localparam logic [15:0] GapLast  = 16'(GAP_LEN - 1);
    localparam logic [15:0] DivLast  = 16'(TONE_DIV - 1);

    typedef enum logic [1:0] {StIdle, StPlay, StGap} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [15:0] r_tdiv, w_tdiv_nxt;
    logic        r_tone, w_tone_nxt;
    logic [1:0]  r_grant, w_grant_nxt;
    logic [1:0]  w_arb_idx;
    logic        w_hold;

    // Arbitration winner among the current requests (meaningful only when req != 0).
    always_comb begin
        w_arb_idx = 2'd0;
`ifdef ALERT_FIXED_PRIORITY_EN
        if (req[0])      w_arb_idx = 2'd0;
        else if (req[1]) w_arb_idx = 2'd1;
        else             w_arb_idx = 2'd2;
`else
        // Search starts just after the last granted channel.
        case (r_grant)
            2'd0: begin
                if (req[1])      w_arb_idx = 2'd1;
                else if (req[2]) w_arb_idx = 2'd2;
                else             w_arb_idx = 2'd0;
            end
            2'd1: begin
                if (req[2])      w_arb_idx = 2'd2;
                else if (req[0]) w_arb_idx = 2'd0;
                else             w_arb_idx = 2'd1;
            end
            default: begin
                if (req[0])      w_arb_idx = 2'd0;
                else if (req[1]) w_arb_idx = 2'd1;
                else             w_arb_idx = 2'd2;
            end
        endcase
`endif
    end

    // Request level of the channel currently holding the slot.
    always_comb begin
        case (r_grant)
            2'd0:    w_hold = req[0];
            2'd1:    w_hold = req[1];
            default: w_hold = req[2];
        endcase
    end

    // Next-state logic; nothing advances while ena is low.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tdiv_nxt  = r_tdiv;
        w_tone_nxt  = r_tone;
        w_grant_nxt = r_grant;
        if (ena) begin
            unique case (r_state)
                StIdle: begin
                    if (|req) begin
                        w_state_nxt = StPlay;
                        w_grant_nxt = w_arb_idx;
                        w_cnt_nxt   = 16'd0;
                        w_tdiv_nxt  = 16'd0;
                        w_tone_nxt  = 1'b0;
                    end
                end
                StPlay: begin
                    if (!w_hold || r_cnt == SlotLast) begin
                        w_state_nxt = StGap;
                        w_cnt_nxt   = 16'd0;
                        w_tdiv_nxt  = 16'd0;
                        w_tone_nxt  = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                        if (r_tdiv == DivLast) begin
                            w_tdiv_nxt = 16'd0;
                            w_tone_nxt = ~r_tone;
                        end else begin
                            w_tdiv_nxt = r_tdiv + 16'd1;
                        end
                    end
                end
                StGap: begin
                    if (r_cnt == GapLast) begin
                        w_cnt_nxt  = 16'd0;
                        w_tdiv_nxt = 16'd0;
                        w_tone_nxt = 1'b0;
                        if (|req) begin
                            w_state_nxt = StPlay;
                            w_grant_nxt = w_arb_idx;
                        end else begin
                            w_state_nxt = StIdle;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                default: begin
                    w_state_nxt = StIdle;
                    w_cnt_nxt   = 16'd0;
                    w_tdiv_nxt  = 16'd0;
                    w_tone_nxt  = 1'b0;
                end
            endcase
        end
    end

    // State registers; grant_idx resets to 2 so the first grant lands on channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= 16'd0;
            r_tdiv  <= 16'd0;
            r_tone  <= 1'b0;
            r_grant <= 2'd2;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tdiv  <= w_tdiv_nxt;
            r_tone  <= w_tone_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Outputs decode from registers only, so reset silences them without a clock.
    always_comb begin
        spk = 3'b000;
        if (r_state == StPlay) begin
            case (r_grant)
                2'd0:    spk = 3'b001;
                2'd1:    spk = 3'b010;
                default: spk = 3'b100;
            endcase
        end
        tone      = r_tone & (r_state == StPlay);
        busy      = (r_state != StIdle);
        grant_idx = r_grant;
    end

endmodule

// File: doc/alert_scheduler.md
ALERT_SCHEDULER -- requirements
Module: alert_scheduler

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-002 Parameter SLOT_LEN, default 1000, PLAY duration in cycles; legal range 1..65535.
REQ-003 Parameter GAP_LEN, default 100, silent cycles between slots; legal range 1..65535.
REQ-004 Parameter TONE_DIV, default 50, tone half-period in cycles; legal range 1..65535.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst  input  1  asynchronous active-high reset.
REQ-007 Port ena  input  1  design enable; low freezes all state and outputs.
REQ-008 Port req  input  3  per-direction alert requests from the validated sensor channels (bit0 left, bit1 centre, bit2 right).
REQ-009 Port spk  output 3  one-hot speaker enable for the granted channel, 0 when silent.
REQ-010 Port tone  output 1  square-wave tone, high only during PLAY.
REQ-011 Port busy  output 1  high in PLAY or GAP.
REQ-012 Port grant_idx  output 2  index of the last granted channel (0..2).

Function
REQ-013 The block SHALL implement three states: IDLE, PLAY, GAP.
REQ-014 IDLE: spk=0, tone=0, busy=0; at an edge with ena=1 and req!=0, latch the arbitration winner into grant_idx and enter PLAY (spk valid one cycle after req is sampled).
REQ-015 Arbitration SHALL be round-robin: search channels starting at (grant_idx+1) mod 3 and grant the first one with req set.
REQ-016 PLAY: spk[grant_idx]=1, others 0; busy=1; slot counter counts the cycles spent in PLAY.
REQ-017 PLAY SHALL last exactly SLOT_LEN cycles if req[grant_idx] stays high, then enter GAP.
REQ-018 If req[grant_idx] is sampled low during PLAY, the next edge SHALL enter GAP (early termination); requests on other channels do not preempt.
REQ-019 tone SHALL be 0 on PLAY entry and toggle every TONE_DIV cycles of PLAY; it is forced 0 outside PLAY.
REQ-020 GAP: spk=0, tone=0, busy=1, for exactly GAP_LEN cycles.
REQ-021 At the last GAP cycle, req!=0 SHALL re-arbitrate directly into PLAY; req=0 enters IDLE.
REQ-022 Counter widths SHALL be 16 bits; counters reset to 0 on every state entry and never wrap within a state.
REQ-023 When ena=0, state, counters, grant_idx and outputs SHALL hold their values; on ena=1 operation resumes from the held values.
REQ-024 A request asserted and dropped entirely within GAP SHALL NOT be granted.

Reset
REQ-025 Asserting rst SHALL immediately force state=IDLE, spk=0, tone=0, busy=0, counters=0, grant_idx=2 (first grant goes to channel 0), regardless of clk or ena.
REQ-026 Reset asserted mid-PLAY SHALL silence spk and tone without waiting for a clock edge.

Configuration
REQ-027 Macro ALERT_FIXED_PRIORITY_EN defined: arbitration SHALL be fixed priority bit0 > bit1 > bit2, ignoring grant_idx.
REQ-028 Macro ALERT_FIXED_PRIORITY_EN undefined: arbitration SHALL be round-robin per REQ-015.

Verification (SLOT_LEN=8, GAP_LEN=2, TONE_DIV=2)
REQ-029 Reset, then req=3'b001 held -> spk=3'b001 for 8 cycles, 2 cycles spk=0 with busy=1, then repeats; grant_idx=0.
REQ-030 req=3'b011 held (round-robin) -> slot sequence spk=001, 010, 001, 010, each 8 cycles, separated by 2 silent cycles.
REQ-031 Same stimulus with ALERT_FIXED_PRIORITY_EN -> every slot spk=001.
REQ-032 req=3'b100, drop to 0 after 3 PLAY cycles -> spk=100 for 3 cycles, GAP 2 cycles, then IDLE with busy=0.
REQ-033 During PLAY, tone pattern 0,0,1,1,0,0,1,1 across the 8 slot cycles; ena low for 5 cycles mid-slot -> all outputs frozen, slot resumes and completes remaining cycles.
REQ-034 rst pulsed asynchronously mid-PLAY -> spk=0, tone=0, busy=0 before next clk edge; next grant after release goes to channel 0.
